inv_key_schedule: RTL and testbench

Sequential reverse AES key schedule for the decryption datapath. From the final Nk words of the expanded key, it regenerates the round keys in descending order: round nr first, round 0 last. Words are produced one per cycle using the inverted expansion recurrence. Each 128-bit round key is handed to the inverse-cipher round logic (AddRoundKey / InvMixColumns) over a valid/ready handshake.

---
 rtl/inv_key_schedule_if.sv | 59 +++++
 rtl/inv_key_schedule.sv | 243 ++++++++++++++++++++++++
 tb/tb_inv_key_schedule.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_key_schedule_if.sv
// ---------------------------------------------------------------------------
// inv_key_schedule_if
//
// Bundles the control and round-key delivery signals of inv_key_schedule.
//
//   start     : begin a run (only acted on while the schedule is idle)
//   last_key  : final Nk expanded-key words, lowest-indexed word in bits [0:31]
//   rk_out    : current round key, word 4r in bits [0:31]
//   rk_round  : round index r of rk_out
//   rk_valid  : rk_out / rk_round are valid
//   rk_ready  : consumer accepts the key
//   busy      : schedule is not idle
//   done      : one-cycle pulse after round 0 has been transferred
//   dbg_state : raw FSM state, for debug and checker binding
//
// Handshake: a round key transfers on every rising clock edge where rk_valid
// and rk_ready are both high. Once rk_valid is raised, rk_out and rk_round
// stay stable and rk_valid stays high until that transfer; rk_valid never
// depends combinationally on rk_ready.
//
// Modports: slave is the schedule side, master is the driver/consumer side.
// ---------------------------------------------------------------------------
interface inv_key_schedule_if #(
  parameter int Nk = 4
);
  logic              start;
  logic [0:32*Nk-1]  last_key;
  logic [0:127]      rk_out;
  logic [3:0]        rk_round;
  logic              rk_valid;
  logic              rk_ready;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  modport slave (
    input  start,
    input  last_key,
    input  rk_ready,
    output rk_out,
    output rk_round,
    output rk_valid,
    output busy,
    output done,
    output dbg_state
  );

  modport master (
    output start,
    output last_key,
    output rk_ready,
    input  rk_out,
    input  rk_round,
    input  rk_valid,
    input  busy,
    input  done,
    input  dbg_state
  );
endinterface

// File: rtl/inv_key_schedule.sv
// ---------------------------------------------------------------------------
// inv_key_schedule
//
// Reverse AES key schedule for the decryption datapath. Starting from the
// last Nk words of the expanded key it walks the expansion recurrence
// backwards, one word per cycle, and hands out the 128-bit round keys in
// descending order (round nr first, round 0 last) over a valid/ready
// handshake.
//
// Parameters:
//   Nk : key length in 32-bit words (4, 6 or 8)
//   nr : number of rounds (10, 12 or 14 matching Nk)
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset, aborts any run
//   bus   : inv_key_schedule_if slave modport (start, last_key, rk_* , busy,
//           done, dbg_state)
//
// Datapath: a window of Nk words w[j..j+Nk-1] (offset 0 = w[j]). While
// emitting, round r is read from window offsets 4r-j .. 4r-j+3. While
// computing, w[j-1] = w[j-1+Nk] ^ f(w[j-2+Nk]) is formed and shifted in at
// offset 0, dropping the top word. A single 4-byte S-box bank serves f().
// ---------------------------------------------------------------------------
module inv_key_schedule #(
  parameter int Nk = 4,
  parameter int nr = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  inv_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EMIT    = 2'd1,
    S_COMPUTE = 2'd2
  } state_t;

  // Lowest word index held by the window when a run starts.
  localparam logic [5:0] J_START = 6'(4 * (nr + 1) - Nk);
  localparam logic [3:0] R_START = 4'(nr);
  localparam logic [5:0] NK6     = 6'(Nk);
  localparam logic [5:0] NK_M1   = 6'(Nk - 1);

  // AES forward S-box, byte b at bits [8b : 8b+7].
  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] win_q [Nk];
  logic [31:0] win_d [Nk];
  logic [5:0]  j_q, j_d;
  logic [3:0]  r_q, r_d;
  logic        done_q, done_d;

  // -------------------------------------------------------------------------
  // Emit path: pick round r's four words out of the window.
  // -------------------------------------------------------------------------
  logic [5:0]   emit_off;
  logic [0:127] emit_key;

  assign emit_off = {r_q, 2'b00} - j_q;

  always_comb begin
    emit_key = '0;
    for (int k = 0; k <= Nk - 4; k++) begin
      if (emit_off == 6'(k)) begin
        emit_key = {win_q[k], win_q[k + 1], win_q[k + 2], win_q[k + 3]};
      end
    end
  end

  // -------------------------------------------------------------------------
  // Compute path: recover w[j-1] from w[i] and w[i-1], i = j-1+Nk.
  // -------------------------------------------------------------------------
  logic [5:0]  i_idx;
  logic [2:0]  i_mod;
  logic [3:0]  i_div;
  logic [31:0] t_word;
  logic [31:0] top_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] f_word;
  logic [31:0] new_word;

  assign i_idx    = j_q + NK_M1;
  assign i_mod    = 3'(i_idx % NK6);
  assign i_div    = 4'(i_idx / NK6);
  assign t_word   = win_q[Nk - 2];
  assign top_word = win_q[Nk - 1];

  // RotWord only feeds the S-box bank on Nk-aligned indices, so the rotate
  // sits in front of the single shared bank instead of duplicating it.
  assign sub_in  = (i_mod == 3'd0) ? {t_word[23:0], t_word[31:24]} : t_word;
  assign sub_out = sub_word(sub_in);

  always_comb begin
    f_word = t_word;
    if (i_mod == 3'd0) begin
      f_word = sub_out ^ {rcon(i_div), 24'h000000};
    end else if ((Nk > 6) && (i_mod == 3'd4)) begin
      f_word = sub_out;
    end
  end

  assign new_word = top_word ^ f_word;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    j_d     = j_q;
    r_d     = r_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int k = 0; k < Nk; k++) begin
            win_d[k] = bus.last_key[32 * k +: 32];
          end
          j_d     = J_START;
          r_d     = R_START;
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (bus.rk_ready) begin
          if (r_q == 4'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            r_d = r_q - 4'd1;
            // Next round is already in the window if its lowest word w[4(r-1)]
            // is at or above j; otherwise words must be regenerated first.
            if (j_q <= {r_q - 4'd1, 2'b00}) begin
              state_d = S_EMIT;
            end else begin
              state_d = S_COMPUTE;
            end
          end
        end
      end

      S_COMPUTE: begin
        win_d[0] = new_word;
        for (int k = 1; k < Nk; k++) begin
          win_d[k] = win_q[k - 1];
        end
        j_d = j_q - 6'd1;
        if ((j_q - 6'd1) <= {r_q, 2'b00}) begin
          state_d = S_EMIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int k = 0; k < Nk; k++) begin
        win_q[k] <= '0;
      end
      j_q    <= '0;
      r_q    <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      j_q     <= j_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: key and round are forced to zero outside EMIT so that idle and
  // compute cycles never show stale window contents.
  // -------------------------------------------------------------------------
  assign bus.rk_valid  = (state_q == S_EMIT);
  assign bus.rk_out    = (state_q == S_EMIT) ? emit_key : '0;
  assign bus.rk_round  = (state_q == S_EMIT) ? r_q : 4'd0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_inv_key_schedule
//
// Bench for inv_key_schedule with two instances: AES-128 (Nk=4, nr=10) and
// AES-256 (Nk=8, nr=14). Expected round keys come from a forward
// KeyExpansion model whose S-box is derived from GF(2^8) inversion plus the
// affine map, and from published test vectors.
// ---------------------------------------------------------------------------
module tb_inv_key_schedule;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inv_key_schedule_if #(.Nk(4)) if4 ();
  inv_key_schedule_if #(.Nk(8)) if8 ();

  inv_key_schedule #(.Nk(4), .nr(10)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  inv_key_schedule #(.Nk(8), .nr(14)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: forward AES KeyExpansion
  // -------------------------------------------------------------------------
  logic [7:0]  sbox_m [256];
  logic [31:0] w_m    [0:59];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    d = d << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // key holds Nk words big-endian starting at bit 255.
  task automatic expand(input logic [255:0] key, input int nk);
    int total = 4 * (nk + 7);
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < nk; i++) w_m[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < total; i++) begin
      logic [31:0] temp = w_m[i - 1];
      if (i % nk == 0) begin
        temp = sub_word_m({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word_m(temp);
      end
      w_m[i] = w_m[i - nk] ^ temp;
    end
  endtask

  function automatic logic [255:0] last_key_of(input int nk);
    logic [255:0] lk = '0;
    int base = 4 * (nk + 7) - nk;
    for (int k = 0; k < nk; k++) lk[255 - 32 * k -: 32] = w_m[base + k];
    return lk;
  endfunction

  function automatic logic [127:0] round_key(input int r);
    return {w_m[4 * r], w_m[4 * r + 1], w_m[4 * r + 2], w_m[4 * r + 3]};
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard: expected {round, key} in delivery order
  // -------------------------------------------------------------------------
  logic [131:0] exp_q[$];

  task automatic load_sb(input int nk);
    exp_q.delete();
    for (int r = nk + 6; r >= 0; r--) exp_q.push_back({4'(r), round_key(r)});
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (sel8 picks the Nk=8 instance)
  // -------------------------------------------------------------------------
  task automatic set_start(input bit sel8, input logic v);
    if (sel8) if8.start = v; else if4.start = v;
  endtask

  task automatic set_ready(input bit sel8, input logic v);
    if (sel8) if8.rk_ready = v; else if4.rk_ready = v;
  endtask

  task automatic set_lk(input bit sel8, input logic [255:0] lk);
    if (sel8) if8.last_key = lk; else if4.last_key = lk[255:128];
  endtask

  task automatic sample(input bit sel8, output logic v, output logic [3:0] rr,
                        output logic [127:0] k, output logic b, output logic d);
    if (sel8) begin
      v = if8.rk_valid; rr = if8.rk_round; k = if8.rk_out; b = if8.busy; d = if8.done;
    end else begin
      v = if4.rk_valid; rr = if4.rk_round; k = if4.rk_out; b = if4.busy; d = if4.done;
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid4"}, if4.rk_valid, 0);
    check({tag, "_busy4"},  if4.busy, 0);
    check({tag, "_done4"},  if4.done, 0);
    check({tag, "_key4"},   if4.rk_out, 0);
    check({tag, "_round4"}, if4.rk_round, 0);
  endtask

  // Result of the latest run, indexed by round.
  logic [127:0] got_key [0:14];
  int           got_cyc [0:14];
  int           done_cyc;

  // One full run. Cycle 1 is the cycle right after the edge that samples start.
  task automatic run_seq(input bit sel8, input logic [255:0] lk, input int ready_pct,
                         input bit use_sb, input int poke_cyc);
    int           c;
    int           next_r;
    bit           fin;
    bit           rdy;
    logic         v, b, d, prev_stall;
    logic [3:0]   rr, prev_round;
    logic [127:0] k, prev_key;
    logic [131:0] e;
    for (int i = 0; i < 15; i++) begin
      got_key[i] = '0;
      got_cyc[i] = -1;
    end
    done_cyc   = -1;
    next_r     = sel8 ? 14 : 10;
    prev_stall = 1'b0;
    prev_key   = '0;
    prev_round = '0;
    fin        = 1'b0;
    set_lk(sel8, lk);
    set_start(sel8, 1'b1);
    @(posedge clk); #1;
    c = 1;
    while (!fin && c < 2000) begin
      set_start(sel8, 1'b0);
      sample(sel8, v, rr, k, b, d);
      if (prev_stall) begin
        check("hold_valid", v, 1);
        check("hold_key", {rr, k}, {prev_round, prev_key});
      end
      if (d) begin
        done_cyc = c;
        check("busy_at_done", b, 0);
        check("all_rounds_before_done", next_r + 1, 0);
        fin = 1'b1;
      end else begin
        check("busy_in_run", b, 1);
        if (c == poke_cyc) begin
          set_start(sel8, 1'b1);
          set_lk(sel8, {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom});
        end
        rdy = ($urandom_range(99) < ready_pct);
        set_ready(sel8, rdy);
        if (v && rdy) begin
          check("round_order", rr, next_r);
          got_key[rr] = k;
          got_cyc[rr] = c;
          if (use_sb) begin
            if (exp_q.size() == 0) begin
              check("sb_extra_key", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("sb_key", {rr, k}, e);
            end
          end
          next_r--;
        end
        prev_stall = v && !rdy;
        prev_key   = k;
        prev_round = rr;
        @(posedge clk); #1;
        c++;
      end
    end
    if (!fin) check("run_timeout", 0, 1);
    if (use_sb) check("sb_empty", exp_q.size(), 0);
    set_ready(sel8, 1'b0);
    set_start(sel8, 1'b0);
    @(posedge clk); #1;
    sample(sel8, v, rr, k, b, d);
    check("done_single_pulse", d, 0);
    check("idle_after_run", {v, b}, 0);
  endtask

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    bit           sel8;
    logic [255:0] lk;
    int           round;
    logic [127:0] exp_key;
    int           exp_cyc;   // -1: cycle not checked
    int           exp_done;  // -1: done cycle not checked
  } vec_t;

  vec_t vecs [8];

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [255:0] key;
    logic [255:0] lk;
    logic [127:0] r10_key;

    vecs[0] = '{0, {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0}, 10,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, 52};
    vecs[1] = '{0, {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0}, 0,
                128'h2b7e151628aed2a6abf7158809cf4f3c, 51, 52};
    vecs[2] = '{0, {128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h0}, 9,
                128'h549932d1f08557681093ed9cbe2c974e, -1, -1};
    vecs[3] = '{0, {128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h0}, 0,
                128'h000102030405060708090a0b0c0d0e0f, -1, -1};
    vecs[4] = '{1, {128'h4e5a6699a9f24fe07e572baacdf8cdea,
                    128'h24fc79ccbf0979e9371ac23c6d68de36}, 14,
                128'h24fc79ccbf0979e9371ac23c6d68de36, 1, -1};
    vecs[5] = '{1, {128'h4e5a6699a9f24fe07e572baacdf8cdea,
                    128'h24fc79ccbf0979e9371ac23c6d68de36}, 13,
                128'h4e5a6699a9f24fe07e572baacdf8cdea, 2, -1};
    vecs[6] = '{1, {128'h4e5a6699a9f24fe07e572baacdf8cdea,
                    128'h24fc79ccbf0979e9371ac23c6d68de36}, 1,
                128'h101112131415161718191a1b1c1d1e1f, -1, -1};
    vecs[7] = '{1, {128'h4e5a6699a9f24fe07e572baacdf8cdea,
                    128'h24fc79ccbf0979e9371ac23c6d68de36}, 0,
                128'h000102030405060708090a0b0c0d0e0f, -1, -1};

    build_sbox();
    if4.start = 1'b0; if4.rk_ready = 1'b0; if4.last_key = '0;
    if8.start = 1'b0; if8.rk_ready = 1'b0; if8.last_key = '0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    check("reset_valid8", if8.rk_valid, 0);
    check("reset_busy8",  if8.busy, 0);
    check("reset_done8",  if8.done, 0);
    check("reset_key8",   if8.rk_out, 0);
    check("reset_round8", if8.rk_round, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer table
    for (int n = 0; n < 8; n++) begin
      run_seq(vecs[n].sel8, vecs[n].lk, 100, 1'b0, -1);
      check($sformatf("vec%0d_key", n), got_key[vecs[n].round], vecs[n].exp_key);
      if (vecs[n].exp_cyc >= 0)
        check($sformatf("vec%0d_cycle", n), got_cyc[vecs[n].round], vecs[n].exp_cyc);
      if (vecs[n].exp_done >= 0)
        check($sformatf("vec%0d_done_cycle", n), done_cyc, vecs[n].exp_done);
    end

    // AES-128 timing per round, random key, ready tied high
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    expand(key, 4);
    load_sb(4);
    run_seq(0, last_key_of(4), 100, 1'b1, -1);
    for (int r = 0; r <= 10; r++) check($sformatf("r%0d_cycle", r), got_cyc[r], 1 + 5 * (10 - r));
    check("done_cycle_rand", done_cyc, 52);

    // Backpressure: first vector, then random keys
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    load_sb(4);
    run_seq(0, last_key_of(4), 50, 1'b1, -1);
    for (int n = 0; n < 3; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      expand(key, 4);
      load_sb(4);
      run_seq(0, last_key_of(4), 50, 1'b1, -1);
    end

    // AES-256 random keys with backpressure
    for (int n = 0; n < 3; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      expand(key, 8);
      load_sb(8);
      run_seq(1, last_key_of(8), (n == 0) ? 100 : 50, 1'b1, -1);
    end

    // start and a new last_key mid-run are ignored
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    expand(key, 4);
    load_sb(4);
    run_seq(0, last_key_of(4), 50, 1'b1, 20);

    // Reset asserted during COMPUTE
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    expand(key, 4);
    set_lk(0, last_key_of(4));
    set_start(0, 1'b1);
    @(posedge clk); #1;             // cycle 1: EMIT round 10
    set_start(0, 1'b0);
    set_ready(0, 1'b1);
    @(posedge clk); #1;             // cycle 2: COMPUTE
    @(posedge clk); #1;             // cycle 3: COMPUTE
    check("pre_reset_compute_valid", if4.rk_valid, 0);
    check("pre_reset_compute_busy", if4.busy, 1);
    rst_n = 1'b0;
    #1;
    check_cleared("reset_in_compute");
    set_ready(0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh full run after the abort
    load_sb(4);
    run_seq(0, last_key_of(4), 100, 1'b1, -1);
    check("done_cycle_after_reset", done_cyc, 52);

    // rk_ready held low: stall indefinitely on round 10
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    expand(key, 4);
    r10_key = round_key(10);
    lk = last_key_of(4);
    set_lk(0, lk);
    set_ready(0, 1'b0);
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      check("stall_valid", if4.rk_valid, 1);
      check("stall_busy", if4.busy, 1);
      check("stall_round", if4.rk_round, 10);
      check("stall_key", if4.rk_out, r10_key);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_cleared("reset_in_stall");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if the sequence above ever stops advancing.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
